// File: rtl/ogpu_buffer_reader.sv
// rtl/ogpu_buffer_reader.sv - Avalon-MM read initiator streaming ogpu buffer RAM words to the quad-fetch pipeline
module ogpu_buffer_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  busy,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_clken,
    output logic                  ram_write,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   rd_addr;
    logic [LEN_W-1:0]    issue_cnt;
    logic [LEN_W-1:0]    deliver_cnt;
    logic                inflight;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      fifo_count;
    logic [PTR_W:0]      occupancy;
    logic                has_credit;
    logic                accept, issue, push, pop;

    // A read in flight already owns a FIFO slot, so it counts against credit.
    assign occupancy  = fifo_count + {{PTR_W{1'b0}}, inflight};
    assign has_credit = occupancy < DEPTH_C;

    assign accept = cmd_valid & cmd_ready;
    assign push   = inflight;
    assign pop    = out_valid & out_ready;

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid & (deliver_cnt == LEN_W'(1));

    assign ram_address    = rd_addr;
    assign ram_chipselect = issue;
    assign ram_clken      = issue;
    assign ram_write      = 1'b0;
    assign ram_byteenable = '1;
    assign ram_writedata  = '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_len != '0)              state_next = ISSUE;
            ISSUE:   if (issue && issue_cnt == LEN_W'(1))         state_next = DRAIN;
            DRAIN:   if (pop && deliver_cnt == LEN_W'(1))         state_next = IDLE;
            default:                                              state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            ISSUE: begin
                busy  = 1'b1;
                issue = has_credit;
            end
            DRAIN:   busy = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr     <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            inflight    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            inflight <= issue;
            if (accept && cmd_len != '0) begin
                rd_addr     <= cmd_addr;
                issue_cnt   <= cmd_len;
                deliver_cnt <= cmd_len;
            end else begin
                if (issue) begin
                    rd_addr   <= rd_addr + ADDR_W'(1);
                    issue_cnt <= issue_cnt - LEN_W'(1);
                end
                if (pop) deliver_cnt <= deliver_cnt - LEN_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // RAM data lands one cycle after its issue; credit guarantees a free slot.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_readdata;
    end

endmodule

// File: tb/tb_ogpu_buffer_reader.sv
// tb/tb_ogpu_buffer_reader.sv - directed self-checking bench for ogpu_buffer_reader
module tb_ogpu_buffer_reader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 14;
    localparam int DEPTH  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [LEN_W-1:0]   cmd_len;
    logic               busy;
    logic [ADDR_W-1:0]  ram_address;
    logic               ram_chipselect;
    logic               ram_clken;
    logic               ram_write;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic [DATA_W-1:0]  ram_writedata;
    logic [DATA_W-1:0]  ram_readdata;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ram [1 << ADDR_W];
    logic [DATA_W-1:0] beat_q[$];
    bit                last_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                outstanding = 0;
    bit                bp_mode = 0;

    always #5 clk = ~clk;

    ogpu_buffer_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .ram_readdata(ram_readdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // RAM model with a registered 1-cycle read
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) ram_readdata <= ram[ram_address];
    end

    always @(posedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            if (ram_chipselect) begin
                check("credit", (outstanding < DEPTH) ? 64'd1 : 64'd0, 64'd1);
                addr_q.push_back(ram_address);
                outstanding++;
            end
            if (out_valid && out_ready) begin
                beat_q.push_back(out_data);
                last_q.push_back(out_last);
                outstanding--;
            end
        end
    end

    task automatic clear_q();
        beat_q.delete();
        last_q.delete();
        addr_q.delete();
    endtask

    task automatic run_cmd(input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (bp_mode) out_ready = (i % 4 == 0) || (i % 4 == 3);
            if (!busy && !out_valid) done = 1;
        end
        if (!done) check("timeout", 64'd0, 64'd1);
        bp_mode = 0;
    endtask

    task automatic check_stream(input string tag, input int addr, input int len);
        int bad = 0;
        int lasts = 0;
        check({tag, "_count"}, 64'(beat_q.size()), 64'(len));
        if (beat_q.size() == len) begin
            for (int i = 0; i < len; i++) begin
                if (beat_q[i] !== 64'(((addr + i) % (1 << ADDR_W)) * 3)) bad++;
                if (last_q[i]) lasts++;
            end
            check({tag, "_data"}, 64'(bad), 64'd0);
            check({tag, "_lasts"}, 64'(lasts), 64'd1);
            check({tag, "_final_last"}, 64'(last_q[len-1]), 64'd1);
        end
    endtask

    initial begin
        int a0 [4] = '{8190, 8191, 0, 1};
        int exp_data [7] = '{0, 0, 30, 33, 36, 39, 0};
        int exp_valid [7] = '{0, 0, 1, 1, 1, 1, 0};
        int exp_last [7] = '{0, 0, 0, 0, 0, 1, 0};
        int exp_busy [7] = '{1, 1, 1, 1, 1, 1, 0};
        bit got_third;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 64'(i * 3);
        ram_readdata = '0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_chipselect", 64'(ram_chipselect), 64'd0);
        check("rst_clken", 64'(ram_clken), 64'd0);
        check("rst_address", 64'(ram_address), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("const_write", 64'(ram_write), 64'd0);
        check("const_byteenable", 64'(ram_byteenable), 64'hff);
        check("const_writedata", ram_writedata, 64'd0);
        reset = 1'b0;

        // Basic read, cycle-exact latency
        clear_q();
        run_cmd(10, 4);
        check("t1_cmd_ready_low", 64'(cmd_ready), 64'd0);
        check("t1_first_addr", 64'(ram_address), 64'd10);
        check("t1_first_cs", 64'(ram_chipselect), 64'd1);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t1_busy_%0d", k), 64'(busy), 64'(exp_busy[k]));
            check($sformatf("t1_valid_%0d", k), 64'(out_valid), 64'(exp_valid[k]));
            check($sformatf("t1_last_%0d", k), 64'(out_last), 64'(exp_last[k]));
            if (exp_valid[k] != 0) check($sformatf("t1_data_%0d", k), out_data, 64'(exp_data[k]));
            @(negedge clk);
        end
        check("t1_cmd_ready_back", 64'(cmd_ready), 64'd1);
        check_stream("t1", 10, 4);

        // Address wrap
        clear_q();
        run_cmd(8190, 4);
        wait_idle(100);
        check("t2_naddr", 64'(addr_q.size()), 64'd4);
        if (addr_q.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("t2_addr_%0d", i), 64'(addr_q[i]), 64'(a0[i]));
        check_stream("t2", 8190, 4);

        // Backpressure 1,0,0,1
        clear_q();
        run_cmd(200, 16);
        bp_mode = 1;
        wait_idle(300);
        out_ready = 1'b1;
        check_stream("t3", 200, 16);

        // Full stall then release
        clear_q();
        out_ready = 1'b0;
        run_cmd(300, 10);
        repeat (20) @(negedge clk);
        check("t4_issued", 64'(addr_q.size()), 64'(DEPTH));
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_data", out_data, 64'd900);
        @(negedge clk);
        check("t4_data_stable", out_data, 64'd900);
        out_ready = 1'b1;
        wait_idle(100);
        check_stream("t4", 300, 10);

        // Zero length
        clear_q();
        run_cmd(5, 0);
        repeat (3) @(negedge clk);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t5_no_reads", 64'(addr_q.size()), 64'd0);

        // Whole buffer
        clear_q();
        run_cmd(0, 8192);
        wait_idle(9000);
        check_stream("t6", 0, 8192);
        if (addr_q.size() == 8192) check("t6_last_addr", 64'(addr_q[8191]), 64'd8191);
        else check("t6_naddr", 64'(addr_q.size()), 64'd8192);

        // Reset on the third beat
        clear_q();
        run_cmd(400, 10);
        got_third = 0;
        for (int i = 0; i < 50 && !got_third; i++) begin
            if (beat_q.size() == 2) got_third = 1;
            else @(negedge clk);
        end
        check("t7_reach_third", 64'(got_third), 64'd1);
        check("t7_third_visible", out_data, 64'(402 * 3));
        reset = 1'b1;
        #1;
        check("t7_rst_valid", 64'(out_valid), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_cs", 64'(ram_chipselect), 64'd0);
        check("t7_rst_last", 64'(out_last), 64'd0);
        check("t7_rst_addr", 64'(ram_address), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_q();
        repeat (4) @(negedge clk);
        check("t7_no_beats", 64'(beat_q.size()), 64'd0);
        run_cmd(100, 2);
        wait_idle(100);
        check_stream("t7", 100, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ogpu_buffer_reader.md
Name: ogpu_buffer_reader

Overview:
- Avalon-MM read initiator that drains the 64-bit on-chip ogpu buffer RAM through its second slave port (s2).
- Accepts a command of (start word address, word count), issues single-cycle reads with a fixed 1-cycle read latency, and presents the words as a valid/ready stream to the GPU quad-fetch pipeline.
- Sits between the buffer RAM and the rasterizer front end.
- Backpressure is absorbed by a small credit-managed FIFO, so the RAM never returns data the block cannot store.

Parameters:
- ADDR_W, 13, RAM word-address width; RAM depth is 2^ADDR_W.
- DATA_W, 64, RAM and stream data width.
- LEN_W, 14, command length width; must satisfy LEN_W = ADDR_W+1 so a full-buffer read is expressible.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  LEN_W  number of words, 0..2^ADDR_W.
- busy  out  1  high from command accept until the last word is consumed.
- ram_address  out  ADDR_W  drives address2.
- ram_chipselect  out  1  drives chipselect2.
- ram_clken  out  1  drives clken2.
- ram_write  out  1  drives write2; constant 0.
- ram_byteenable  out  DATA_W/8  drives byteenable2; constant all-ones.
- ram_writedata  out  DATA_W  drives writedata2; constant 0.
- ram_readdata  in  DATA_W  from readdata2.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink ready; a beat transfers on out_valid & out_ready.
- out_data  out  DATA_W  stream word.
- out_last  out  1  marks the final word of a command.

Behaviour:
Reset values:
- State is IDLE.
- cmd_ready = 1 (combinational from IDLE).
- busy, ram_chipselect, ram_clken, out_valid, out_last = 0.
- ram_address = 0; FIFO is empty.
- Reset asserted mid-transfer discards all in-flight and queued data; no out_valid beat follows deassertion.

States:
- IDLE: cmd_ready=1. On accept with cmd_len=0, stay in IDLE with busy=0; no RAM access occurs. On accept with cmd_len>0, latch the address into rd_addr and the length into issue_cnt and deliver_cnt, then go to ISSUE.
- ISSUE: a read is issued in any cycle where credit = FIFO_DEPTH - (fifo_count + inflight) > 0. An issue cycle drives ram_chipselect=1, ram_clken=1, ram_address=rd_addr; then rd_addr increments and wraps modulo 2^ADDR_W (e.g. 8191 to 0), and issue_cnt decrements. In a non-issue cycle, ram_chipselect=0 and ram_clken=0, which stalls the RAM address. When issue_cnt reaches 0, go to DRAIN.
- DRAIN: wait until deliver_cnt reaches 0 and the FIFO is empty, then go to IDLE. cmd_ready stays 0 throughout.

Read latency and capture:
- inflight is a 1-bit register set on each issue cycle.
- ram_readdata is written into the FIFO in the cycle after an issue, unconditionally; credit guarantees space.
- Sustained throughput is 1 word/clk when out_ready is held high. The first word reaches out_valid 2 cycles after command accept: issue, capture, then visible from the FIFO head.

Stream:
- out_valid = FIFO not empty; out_data = FIFO head.
- out_last = 1 when the head word is the command's final word (deliver_cnt = 1 at the head).
- deliver_cnt decrements on each transferred beat.
- out_valid, out_data, and out_last are held stable while out_valid & ~out_ready.
- A FIFO push and pop in the same cycle are both honoured; fifo_count is unchanged.

busy:
- Set on accept of a nonzero command.
- Cleared in the cycle after the beat with out_last is transferred.

Test Plan:
- Preload RAM[i]=i*3. cmd_addr=10, cmd_len=4, out_ready=1 -> out_data 30,33,36,39 on 4 consecutive cycles starting 2 cycles after accept; out_last only on 39; busy drops the following cycle.
- Wrap-around: cmd_addr=8190, cmd_len=4 -> ram_address sequence 8190,8191,0,1; data matches those locations.
- Backpressure: cmd_len=16, out_ready toggles 1,0,0,1 pattern -> all 16 words in order, none dropped or duplicated. Assert that fifo_count never exceeds FIFO_DEPTH and that ram_chipselect=0 whenever credit=0.
- Stall: out_ready=0 for 20 cycles -> exactly FIFO_DEPTH reads issued, out_data stable. Release -> remaining words stream.
- Edge lengths: cmd_len=0 -> no ram_chipselect, busy stays 0, cmd_ready stays 1. cmd_len=8192 from addr 0 -> 8192 beats, last beat is address 8191.
- Reset mid-transfer: assert reset on the 3rd beat of a 10-word command -> all outputs 0 immediately. After release, a new cmd_addr=100, cmd_len=2 returns exactly RAM[100], RAM[101].
